// File: rtl/ibex_rf_wb_arbiter_if.sv
// ----------------------------------------------------------------------------
// ibex_rf_wb_arbiter_if
//
// Purpose:
//    Bundles the writeback-side signals of the register file write arbiter:
//    the ALU write request, the LSU result handshake, the registered register
//    file write port, the ID-stage hazard query and the status outputs.
//
// Modports:
//    slave  - the arbiter itself (consumes requests, drives rf/hazard/status)
//    master - the core side (drives requests, observes rf/hazard/status)
//
// Signals:
//    alu_we_i / alu_waddr_i / alu_wdata_i   ALU writeback request
//    lsu_valid_i / lsu_ready_o              LSU result handshake
//    lsu_waddr_i / lsu_wdata_i              LSU result payload
//    rf_we_o / rf_waddr_o / rf_wdata_o      register file write port
//    hz_raddr_a_i / hz_raddr_b_i            hazard query addresses
//    hz_a_o / hz_b_o                        queued-write hazard flags
//    alu_stall_o                            starvation stall request
//    err_o                                  sticky protocol error
// ----------------------------------------------------------------------------
interface ibex_rf_wb_arbiter_if #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 5
);

    logic                 alu_we_i;
    logic [AddrWidth-1:0] alu_waddr_i;
    logic [DataWidth-1:0] alu_wdata_i;

    logic                 lsu_valid_i;
    logic                 lsu_ready_o;
    logic [AddrWidth-1:0] lsu_waddr_i;
    logic [DataWidth-1:0] lsu_wdata_i;

    logic                 rf_we_o;
    logic [AddrWidth-1:0] rf_waddr_o;
    logic [DataWidth-1:0] rf_wdata_o;

    logic [AddrWidth-1:0] hz_raddr_a_i;
    logic [AddrWidth-1:0] hz_raddr_b_i;
    logic                 hz_a_o;
    logic                 hz_b_o;

    logic                 alu_stall_o;
    logic                 err_o;

    modport slave (
        input  alu_we_i, alu_waddr_i, alu_wdata_i,
        input  lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
        output lsu_ready_o,
        output rf_we_o, rf_waddr_o, rf_wdata_o,
        input  hz_raddr_a_i, hz_raddr_b_i,
        output hz_a_o, hz_b_o,
        output alu_stall_o, err_o
    );

    modport master (
        output alu_we_i, alu_waddr_i, alu_wdata_i,
        output lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
        input  lsu_ready_o,
        input  rf_we_o, rf_waddr_o, rf_wdata_o,
        output hz_raddr_a_i, hz_raddr_b_i,
        input  hz_a_o, hz_b_o,
        input  alu_stall_o, err_o
    );

endinterface

// File: rtl/ibex_rf_wb_arbiter.sv
// ----------------------------------------------------------------------------
// ibex_rf_wb_arbiter
//
// Purpose:
//    Merges the single-cycle ALU writeback and the long-latency LSU/MAC
//    writeback onto the register file's single write port. LSU results that
//    cannot be written immediately wait in a small FIFO. The ALU always has
//    priority unless the FIFO has been starved for StarveLimit cycles, in
//    which case alu_stall_o asks the core to hold off ALU writes for a cycle.
//    An ALU write is younger than everything queued, so it squashes queued
//    (and same-cycle) LSU results to the same register.
//
// Ports:
//    clk_i  - clock
//    rst_i  - synchronous active-high reset
//    bus    - ibex_rf_wb_arbiter_if.slave (ALU/LSU requests, rf write port,
//             hazard query, stall and error status)
// ----------------------------------------------------------------------------
module ibex_rf_wb_arbiter #(
    parameter int DataWidth   = 32,
    parameter int AddrWidth   = 5,
    parameter int FifoDepth   = 2,
    parameter int StarveLimit = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    ibex_rf_wb_arbiter_if.slave  bus
);

    localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int CntW = PtrW + 1;
    localparam int StW  = $clog2(StarveLimit + 1);

    localparam logic [CntW-1:0] FullCount = CntW'(FifoDepth);
    localparam logic [StW-1:0]  StarveMax = StW'(StarveLimit);

    // FIFO storage; a cleared valid bit marks an entry squashed by a younger
    // ALU write to the same register (it still pops, but writes nothing).
    logic                 r_fifoValid [FifoDepth];
    logic [AddrWidth-1:0] r_fifoAddr  [FifoDepth];
    logic [DataWidth-1:0] r_fifoData  [FifoDepth];
    logic [PtrW-1:0]      r_rdPtr;
    logic [PtrW-1:0]      r_wrPtr;
    logic [CntW-1:0]      r_count;

    logic [StW-1:0]       r_starveCnt;
    logic                 r_err;

    logic                 r_rfWe;
    logic [AddrWidth-1:0] r_rfWaddr;
    logic [DataWidth-1:0] r_rfWdata;

    logic w_full;
    logic w_empty;
    logic w_lsuReady;
    logic w_lsuHs;
    logic w_aluStall;
    logic w_aluReq;
    logic w_aluWin;
    logic w_pop;
    logic w_headValid;
    logic w_bypass;
    logic w_lsuSquash;
    logic w_push;
    logic w_protoErr;
    logic w_hzA;
    logic w_hzB;

    // Arbitration: ALU first (unless stalled), then the FIFO head, then a
    // zero-bubble LSU bypass when nothing is queued. LSU results to x0 and
    // results squashed by a same-cycle ALU write complete the handshake but
    // are dropped.
    always_comb begin
        w_full      = (r_count == FullCount);
        w_empty     = (r_count == '0);
        w_lsuReady  = !rst_i && !w_full;
        w_lsuHs     = bus.lsu_valid_i && w_lsuReady;
        w_aluStall  = (r_starveCnt == StarveMax);
        w_aluReq    = bus.alu_we_i && (bus.alu_waddr_i != '0);
        w_aluWin    = w_aluReq && !w_aluStall;
        w_protoErr  = w_aluReq && w_aluStall;
        w_pop       = !w_aluWin && !w_empty;
        w_headValid = r_fifoValid[r_rdPtr];
        w_bypass    = !w_aluWin && w_empty && w_lsuHs && (bus.lsu_waddr_i != '0);
        w_lsuSquash = w_aluWin && (bus.lsu_waddr_i == bus.alu_waddr_i);
        w_push      = w_lsuHs && (bus.lsu_waddr_i != '0) && !w_bypass && !w_lsuSquash;
    end

    // Hazard flags look only at live (non-squashed) queued entries; x0 is
    // never a hazard since writes to it are never queued or performed.
    always_comb begin
        w_hzA = 1'b0;
        w_hzB = 1'b0;
        for (int i = 0; i < FifoDepth; i++) begin
            if (r_fifoValid[i] && (r_fifoAddr[i] == bus.hz_raddr_a_i)) begin
                w_hzA = 1'b1;
            end
            if (r_fifoValid[i] && (r_fifoAddr[i] == bus.hz_raddr_b_i)) begin
                w_hzB = 1'b1;
            end
        end
        if (bus.hz_raddr_a_i == '0) begin
            w_hzA = 1'b0;
        end
        if (bus.hz_raddr_b_i == '0) begin
            w_hzB = 1'b0;
        end
    end

    // State update: FIFO push/pop/squash, starvation counter, sticky error
    // and the registered write port. The write port only updates address and
    // data when it actually writes, so they hold their last value otherwise.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < FifoDepth; i++) begin
                r_fifoValid[i] <= 1'b0;
                r_fifoAddr[i]  <= '0;
                r_fifoData[i]  <= '0;
            end
            r_rdPtr     <= '0;
            r_wrPtr     <= '0;
            r_count     <= '0;
            r_starveCnt <= '0;
            r_err       <= 1'b0;
            r_rfWe      <= 1'b0;
            r_rfWaddr   <= '0;
            r_rfWdata   <= '0;
        end else begin
            if (w_aluWin) begin
                for (int i = 0; i < FifoDepth; i++) begin
                    if (r_fifoAddr[i] == bus.alu_waddr_i) begin
                        r_fifoValid[i] <= 1'b0;
                    end
                end
            end

            if (w_pop) begin
                r_fifoValid[r_rdPtr] <= 1'b0;
                r_rdPtr              <= r_rdPtr + PtrW'(1);
            end

            if (w_push) begin
                r_fifoValid[r_wrPtr] <= 1'b1;
                r_fifoAddr[r_wrPtr]  <= bus.lsu_waddr_i;
                r_fifoData[r_wrPtr]  <= bus.lsu_wdata_i;
                r_wrPtr              <= r_wrPtr + PtrW'(1);
            end

            if (w_push && !w_pop) begin
                r_count <= r_count + CntW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CntW'(1);
            end

            if (w_empty || w_pop) begin
                r_starveCnt <= '0;
            end else if (r_starveCnt != StarveMax) begin
                r_starveCnt <= r_starveCnt + StW'(1);
            end

            if (w_protoErr) begin
                r_err <= 1'b1;
            end

            r_rfWe <= w_aluWin || (w_pop && w_headValid) || w_bypass;
            if (w_aluWin) begin
                r_rfWaddr <= bus.alu_waddr_i;
                r_rfWdata <= bus.alu_wdata_i;
            end else if (w_pop && w_headValid) begin
                r_rfWaddr <= r_fifoAddr[r_rdPtr];
                r_rfWdata <= r_fifoData[r_rdPtr];
            end else if (w_bypass) begin
                r_rfWaddr <= bus.lsu_waddr_i;
                r_rfWdata <= bus.lsu_wdata_i;
            end
        end
    end

    assign bus.lsu_ready_o = w_lsuReady;
    assign bus.rf_we_o     = r_rfWe;
    assign bus.rf_waddr_o  = r_rfWaddr;
    assign bus.rf_wdata_o  = r_rfWdata;
    assign bus.hz_a_o      = w_hzA;
    assign bus.hz_b_o      = w_hzB;
    assign bus.alu_stall_o = w_aluStall;
    assign bus.err_o       = r_err;

endmodule

// File: tb/tb_ibex_rf_wb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ibex_rf_wb_arbiter
//
// Purpose:
//    Directed testbench for ibex_rf_wb_arbiter with hand-computed expected
//    values: reset, ALU writes, LSU queueing with starvation stall, WAW
//    squash, bypass, x0 handling and the sticky protocol error.
// ----------------------------------------------------------------------------
module tb_ibex_rf_wb_arbiter;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    int errors = 0;
    int checks = 0;

    ibex_rf_wb_arbiter_if #(.DataWidth(32), .AddrWidth(5)) bus ();

    ibex_rf_wb_arbiter #(
        .DataWidth  (32),
        .AddrWidth  (5),
        .FifoDepth  (2),
        .StarveLimit(4)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus  (bus.slave)
    );

    // Free-running 10 ns clock
    always #5 clk_i = ~clk_i;

    // Single comparison point: counts every check and reports a mismatch
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of requests, then step past the rising edge so the
    // registered results of that cycle are visible
    task automatic applyStimulus(input logic aluWe, input logic [4:0] aluAddr,
                                 input logic [31:0] aluData, input logic lsuValid,
                                 input logic [4:0] lsuAddr, input logic [31:0] lsuData);
        bus.alu_we_i    = aluWe;
        bus.alu_waddr_i = aluAddr;
        bus.alu_wdata_i = aluData;
        bus.lsu_valid_i = lsuValid;
        bus.lsu_waddr_i = lsuAddr;
        bus.lsu_wdata_i = lsuData;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    // Directed sequence
    initial begin
        bus.alu_we_i     = 1'b0;
        bus.alu_waddr_i  = '0;
        bus.alu_wdata_i  = '0;
        bus.lsu_valid_i  = 1'b0;
        bus.lsu_waddr_i  = '0;
        bus.lsu_wdata_i  = '0;
        bus.hz_raddr_a_i = '0;
        bus.hz_raddr_b_i = '0;

        // Reset held for two cycles
        rst_i = 1'b1;
        idleCycle();
        idleCycle();
        checkOutput("rst_we",    32'(bus.rf_we_o),     32'd0);
        checkOutput("rst_stall", 32'(bus.alu_stall_o), 32'd0);
        checkOutput("rst_err",   32'(bus.err_o),       32'd0);
        checkOutput("rst_ready", 32'(bus.lsu_ready_o), 32'd0);
        rst_i = 1'b0;
        #1;
        checkOutput("post_rst_ready", 32'(bus.lsu_ready_o), 32'd1);
        checkOutput("post_rst_waddr", 32'(bus.rf_waddr_o),  32'd0);

        // Plain ALU write, then an ALU write to x0
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
        checkOutput("alu_we",    32'(bus.rf_we_o),    32'd1);
        checkOutput("alu_waddr", 32'(bus.rf_waddr_o), 32'd5);
        checkOutput("alu_wdata", bus.rf_wdata_o,      32'hDEADBEEF);
        applyStimulus(1'b1, 5'd0, 32'h00000123, 1'b0, 5'd0, 32'h0);
        checkOutput("x0_we",         32'(bus.rf_we_o),    32'd0);
        checkOutput("x0_hold_waddr", 32'(bus.rf_waddr_o), 32'd5);
        checkOutput("x0_hold_wdata", bus.rf_wdata_o,      32'hDEADBEEF);

        // ALU hogs the port while the LSU queues x7 then x8
        bus.hz_raddr_a_i = 5'd7;
        bus.hz_raddr_b_i = 5'd8;
        applyStimulus(1'b1, 5'd3, 32'h300, 1'b1, 5'd7, 32'h11);
        checkOutput("q_alu_waddr", 32'(bus.rf_waddr_o),  32'd3);
        checkOutput("q_alu_wdata", bus.rf_wdata_o,       32'h300);
        checkOutput("q_ready1",    32'(bus.lsu_ready_o), 32'd1);
        checkOutput("q_hz_x7",     32'(bus.hz_a_o),      32'd1);
        applyStimulus(1'b1, 5'd3, 32'h301, 1'b1, 5'd8, 32'h22);
        checkOutput("q_ready_full", 32'(bus.lsu_ready_o), 32'd0);
        checkOutput("q_hz_x8",      32'(bus.hz_b_o),      32'd1);
        checkOutput("q_stall_c1",   32'(bus.alu_stall_o), 32'd0);
        applyStimulus(1'b1, 5'd3, 32'h302, 1'b0, 5'd0, 32'h0);
        checkOutput("q_stall_c2", 32'(bus.alu_stall_o), 32'd0);
        applyStimulus(1'b1, 5'd3, 32'h303, 1'b0, 5'd0, 32'h0);
        checkOutput("q_stall_c3", 32'(bus.alu_stall_o), 32'd0);
        applyStimulus(1'b1, 5'd3, 32'h304, 1'b0, 5'd0, 32'h0);
        checkOutput("q_stall_c4", 32'(bus.alu_stall_o), 32'd1);
        checkOutput("q_wdata_c4", bus.rf_wdata_o,       32'h304);
        idleCycle();
        checkOutput("q_x7_we",    32'(bus.rf_we_o),     32'd1);
        checkOutput("q_x7_waddr", 32'(bus.rf_waddr_o),  32'd7);
        checkOutput("q_x7_wdata", bus.rf_wdata_o,       32'h11);
        checkOutput("q_stall_clr",32'(bus.alu_stall_o), 32'd0);
        checkOutput("q_hz_x7_clr",32'(bus.hz_a_o),      32'd0);
        idleCycle();
        checkOutput("q_x8_waddr", 32'(bus.rf_waddr_o),  32'd8);
        checkOutput("q_x8_wdata", bus.rf_wdata_o,       32'h22);
        checkOutput("q_ready_ret",32'(bus.lsu_ready_o), 32'd1);
        idleCycle();
        checkOutput("q_idle_we",  32'(bus.rf_we_o),     32'd0);

        // WAW squash: x9 queued behind x10, then ALU overwrites x9
        bus.hz_raddr_a_i = 5'd9;
        bus.hz_raddr_b_i = 5'd10;
        applyStimulus(1'b1, 5'd3, 32'h333, 1'b1, 5'd10, 32'hA0);
        applyStimulus(1'b1, 5'd3, 32'h334, 1'b1, 5'd9, 32'hAA);
        checkOutput("w_hz_x9_set", 32'(bus.hz_a_o), 32'd1);
        applyStimulus(1'b1, 5'd9, 32'hBB, 1'b0, 5'd0, 32'h0);
        checkOutput("w_alu_x9_waddr", 32'(bus.rf_waddr_o), 32'd9);
        checkOutput("w_alu_x9_wdata", bus.rf_wdata_o,      32'hBB);
        checkOutput("w_hz_x9_clr",    32'(bus.hz_a_o),     32'd0);
        checkOutput("w_hz_x10_keep",  32'(bus.hz_b_o),     32'd1);
        idleCycle();
        checkOutput("w_x10_we",    32'(bus.rf_we_o),    32'd1);
        checkOutput("w_x10_waddr", 32'(bus.rf_waddr_o), 32'd10);
        checkOutput("w_x10_wdata", bus.rf_wdata_o,      32'hA0);
        idleCycle();
        checkOutput("w_squash_we",   32'(bus.rf_we_o),    32'd0);
        checkOutput("w_squash_hold", 32'(bus.rf_waddr_o), 32'd10);
        idleCycle();
        checkOutput("w_empty_we", 32'(bus.rf_we_o), 32'd0);

        // Zero-bubble bypass into an empty FIFO, then an LSU result to x0
        bus.hz_raddr_a_i = 5'd4;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h55);
        checkOutput("b_we",    32'(bus.rf_we_o),     32'd1);
        checkOutput("b_waddr", 32'(bus.rf_waddr_o),  32'd4);
        checkOutput("b_wdata", bus.rf_wdata_o,       32'h55);
        checkOutput("b_hz",    32'(bus.hz_a_o),      32'd0);
        checkOutput("b_ready", 32'(bus.lsu_ready_o), 32'd1);
        bus.hz_raddr_a_i = 5'd0;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h99);
        checkOutput("lsu_x0_we",    32'(bus.rf_we_o),     32'd0);
        checkOutput("lsu_x0_hold",  32'(bus.rf_waddr_o),  32'd4);
        checkOutput("lsu_x0_ready", 32'(bus.lsu_ready_o), 32'd1);
        idleCycle();
        checkOutput("lsu_x0_notq",  32'(bus.rf_we_o),     32'd0);

        // Protocol violation: ALU write to x6 while stalled
        bus.hz_raddr_a_i = 5'd6;
        applyStimulus(1'b1, 5'd3, 32'h400, 1'b1, 5'd7, 32'h77);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 5'd3, 32'h401 + 32'(i), 1'b0, 5'd0, 32'h0);
        end
        checkOutput("e_stall", 32'(bus.alu_stall_o), 32'd1);
        applyStimulus(1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'h0);
        checkOutput("e_head_waddr", 32'(bus.rf_waddr_o), 32'd7);
        checkOutput("e_head_wdata", bus.rf_wdata_o,      32'h77);
        checkOutput("e_err_set",    32'(bus.err_o),      32'd1);
        checkOutput("e_hz_x6",      32'(bus.hz_a_o),     32'd0);
        idleCycle();
        checkOutput("e_no_x6_we",   32'(bus.rf_we_o),    32'd0);
        idleCycle();
        idleCycle();
        checkOutput("e_err_sticky", 32'(bus.err_o),      32'd1);
        checkOutput("e_no_x6_addr", 32'(bus.rf_waddr_o), 32'd7);

        // Reset clears the sticky error
        rst_i = 1'b1;
        idleCycle();
        checkOutput("r_err_clr",  32'(bus.err_o),       32'd0);
        checkOutput("r_ready",    32'(bus.lsu_ready_o), 32'd0);
        checkOutput("r_waddr",    32'(bus.rf_waddr_o),  32'd0);
        rst_i = 1'b0;
        #1;
        checkOutput("r_ready_rel", 32'(bus.lsu_ready_o), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ibex_rf_wb_arbiter.md
Name: ibex_rf_wb_arbiter

Overview:
- Write-side front end for the core register file: merges the single-cycle ALU writeback and the long-latency LSU/MAC writeback into the register file's single write port.
- LSU results queue in a small FIFO.
- Ordering, x0 and write-after-write rules are enforced here.
- Hazard flags for the ID stage and a starvation stall request for the ALU path are generated here.
- Sits between the writeback stage and the register file write port (we/waddr/wdata).

Parameters:
DataWidth, 32, register width
AddrWidth, 5, register address width (4 for RV32E)
FifoDepth, 2, LSU queue entries; power of two, >=2
StarveLimit, 4, consecutive non-draining cycles with FIFO non-empty before alu_stall_o; >=1

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
alu_we_i  in  1  ALU write request; never back-pressured
alu_waddr_i  in  AddrWidth  ALU destination register
alu_wdata_i  in  DataWidth  ALU result
lsu_valid_i  in  1  LSU result valid
lsu_ready_o  out  1  LSU result accepted when valid&&ready
lsu_waddr_i  in  AddrWidth  LSU destination register
lsu_wdata_i  in  DataWidth  LSU result
rf_we_o  out  1  register file write enable (registered)
rf_waddr_o  out  AddrWidth  register file write address (registered)
rf_wdata_o  out  DataWidth  register file write data (registered)
hz_raddr_a_i  in  AddrWidth  hazard query address A
hz_raddr_b_i  in  AddrWidth  hazard query address B
hz_a_o  out  1  A has a queued LSU write pending
hz_b_o  out  1  B has a queued LSU write pending
alu_stall_o  out  1  request that the core withholds ALU writes
err_o  out  1  sticky protocol error

Behaviour:
- Reset: synchronous on rst_i. While rst_i is high and the cycle after, all outputs are 0, except that lsu_ready_o follows the FIFO state once reset is released. FIFO is emptied, starvation counter is 0, err_o is 0.
- Ready rule: lsu_ready_o = !rst_i && !full. It depends only on state, never on lsu_valid_i.
- Latency: 1 cycle from the winning request to rf_we_o/rf_waddr_o/rf_wdata_o. Outputs hold the last address/data when rf_we_o=0.
- Each cycle, the output stage selects in priority order:
  - (a) if alu_stall_o=0 and alu_we_i and alu_waddr_i!=0: the ALU write;
  - (b) else if the FIFO is non-empty: the head entry is popped, and written only if its valid bit is set;
  - (c) else if an LSU handshake with lsu_waddr_i!=0 occurs: the LSU write bypasses the FIFO (zero-bubble);
  - (d) else rf_we_o=0 next cycle.
- LSU enqueue: a handshake not consumed by (c) pushes {valid, addr, data}. Push and pop in the same cycle are allowed; occupancy is unchanged.
- x0: ALU writes to address 0 are ignored. LSU results to address 0 complete the handshake but are discarded and never enqueued.
- WAW squash: the ALU is younger than every queued entry and than any same-cycle LSU result. An ALU write (case a) to address X clears the valid bit of every FIFO entry with address X. A same-cycle LSU result to X is accepted and discarded. Squashed entries still pop in FIFO order without writing.
- Hazards: hz_a_o / hz_b_o are combinational. Each is 1 if any valid FIFO entry matches the query address. The query address must be non-zero; address 0 always returns 0.
- Starvation counter:
  - Increments (saturating at StarveLimit) on each cycle where the FIFO is non-empty and no pop occurs.
  - Clears on a pop or when the FIFO is empty.
  - alu_stall_o = (cnt==StarveLimit), driven from the register.
- While alu_stall_o=1: the FIFO head wins, so the counter clears next cycle. An alu_we_i with non-zero address in that cycle is a protocol violation: the write is dropped and err_o is set sticky until reset.
- Reset mid-operation: queued entries are lost and no partial write is emitted. The block does not guarantee the register file contents.

Test Plan:
- Reset with rst_i=1 for 2 cycles -> rf_we_o=0, alu_stall_o=0, err_o=0, lsu_ready_o=0 during reset and 1 after.
- ALU writes x5=0xDEADBEEF, no LSU traffic -> next cycle rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0xDEADBEEF. ALU write to x0 -> rf_we_o=0.
- ALU writes x3 every cycle while LSU sends x7=0x11 then x8=0x22:
  - lsu_ready_o drops after 2 accepts;
  - hz on x7=1;
  - alu_stall_o rises after 4 cycles;
  - x7 is then written, counter clears, x8 follows.
- LSU x9=0xAA is queued behind a blocked head, then the ALU writes x9=0xBB -> hz on x9 clears immediately; x9 is later written once with 0xBB only, and the squashed entry pops with rf_we_o=0.
- FIFO empty, no ALU, LSU x4=0x55 -> rf_we_o=1 for x4 next cycle (bypass), and the FIFO stays empty.
- alu_we_i=1 (x6) while alu_stall_o=1 -> the x6 write never appears, and err_o=1 stays high until rst_i.
